// File: rtl/neuron_feeder.sv
// Operand feeder for the neuron core: stores M input/weight byte pairs from the host,
// streams them one pair per BEAT cycles on go, then captures the core result or flags a timeout.
module neuron_feeder #(
    parameter int unsigned N       = 18,
    parameter int unsigned M       = 4,
    parameter int unsigned AW      = 2,
    parameter int unsigned BEAT    = 2,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_in,
    input  logic [7:0]    wr_weight,
    input  logic          go,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [N-1:0]  result,
    output logic          nrn_start,
    output logic [7:0]    nrn_in,
    output logic [7:0]    nrn_weight,
    input  logic [N-1:0]  nrn_out,
    input  logic          nrn_ready
);

    localparam int unsigned BW = (BEAT > 1) ? $clog2(BEAT) : 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT - 1);
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);
    localparam logic [AW-1:0] PAIR_LAST = AW'(M - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_FEED, S_WAIT, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  pair_q, pair_d;
    logic [BW-1:0]  beat_q, beat_d;
    logic [TW-1:0]  wait_q, wait_d;
    logic [7:0]     mem_in_q [M];
    logic [7:0]     mem_in_d [M];
    logic [7:0]     mem_w_q  [M];
    logic [7:0]     mem_w_d  [M];
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic [N-1:0]   result_q, result_d;
    logic           nrn_start_q, nrn_start_d;
    logic [7:0]     nrn_in_q, nrn_in_d;
    logic [7:0]     nrn_weight_q, nrn_weight_d;

    // Next state, counters and memory; outputs are derived from the next state so they register cleanly.
    always_comb begin
        state_d  = state_q;
        pair_d   = pair_q;
        beat_d   = beat_q;
        wait_d   = wait_q;
        err_d    = err_q;
        result_d = result_q;
        mem_in_d = mem_in_q;
        mem_w_d  = mem_w_q;

        case (state_q)
            S_IDLE: begin
                if (wr_en && (32'(wr_addr) < M)) begin
                    mem_in_d[wr_addr] = wr_in;
                    mem_w_d[wr_addr]  = wr_weight;
                end
                if (go) begin
                    state_d = S_START;
                    pair_d  = '0;
                    beat_d  = '0;
                    err_d   = 1'b0;
                end
            end
            S_START, S_FEED: begin
                if (beat_q == BEAT_LAST) begin
                    beat_d = '0;
                    if (pair_q == PAIR_LAST) begin
                        state_d = S_WAIT;
                        wait_d  = '0;
                    end else begin
                        pair_d  = AW'(pair_q + 1'b1);
                        state_d = S_FEED;
                    end
                end else begin
                    beat_d  = BW'(beat_q + 1'b1);
                    state_d = S_FEED;
                end
            end
            S_WAIT: begin
                if (nrn_ready) begin
                    result_d = nrn_out;
                    state_d  = S_DONE;
                end else if (wait_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wait_d = TW'(wait_q + 1'b1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
        nrn_start_d  = (state_d == S_START);
        nrn_in_d     = 8'h00;
        nrn_weight_d = 8'h00;
        // Reading the post-write memory gives write-first behaviour when wr_en and go coincide.
        if ((state_d == S_START) || (state_d == S_FEED)) begin
            nrn_in_d     = mem_in_d[pair_d];
            nrn_weight_d = mem_w_d[pair_d];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            pair_q       <= '0;
            beat_q       <= '0;
            wait_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            result_q     <= '0;
            nrn_start_q  <= 1'b0;
            nrn_in_q     <= 8'h00;
            nrn_weight_q <= 8'h00;
            for (int i = 0; i < int'(M); i++) begin
                mem_in_q[i] <= 8'h00;
                mem_w_q[i]  <= 8'h00;
            end
        end else begin
            state_q      <= state_d;
            pair_q       <= pair_d;
            beat_q       <= beat_d;
            wait_q       <= wait_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            result_q     <= result_d;
            nrn_start_q  <= nrn_start_d;
            nrn_in_q     <= nrn_in_d;
            nrn_weight_q <= nrn_weight_d;
            mem_in_q     <= mem_in_d;
            mem_w_q      <= mem_w_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign result     = result_q;
    assign nrn_start  = nrn_start_q;
    assign nrn_in     = nrn_in_q;
    assign nrn_weight = nrn_weight_q;

endmodule

// File: tb/tb_neuron_feeder.sv
// Directed bench for neuron_feeder: default instance plus a BEAT=1, M=2 instance.
module tb_neuron_feeder;

    logic        clk, rst;
    logic        wr_en, go, busy, done, err, nrn_start, nrn_ready;
    logic [1:0]  wr_addr;
    logic [7:0]  wr_in, wr_weight, nrn_in, nrn_weight;
    logic [17:0] result, nrn_out;

    logic        b_wr_en, b_go, b_busy, b_done, b_err, b_nrn_start, b_nrn_ready;
    logic [0:0]  b_wr_addr;
    logic [7:0]  b_wr_in, b_wr_weight, b_nrn_in, b_nrn_weight;
    logic [17:0] b_result, b_nrn_out;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic       start;
        logic       bsy;
        logic       dn;
        logic [7:0] in_b;
        logic [7:0] w_b;
    } exp_t;

    exp_t        cur [11];
    logic [17:0] exp_res;

    neuron_feeder dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_in(wr_in),
        .wr_weight(wr_weight), .go(go), .busy(busy), .done(done), .err(err),
        .result(result), .nrn_start(nrn_start), .nrn_in(nrn_in),
        .nrn_weight(nrn_weight), .nrn_out(nrn_out), .nrn_ready(nrn_ready)
    );

    neuron_feeder #(.N(18), .M(2), .AW(1), .BEAT(1), .TIMEOUT(64)) dut6 (
        .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_in(b_wr_in),
        .wr_weight(b_wr_weight), .go(b_go), .busy(b_busy), .done(b_done), .err(b_err),
        .result(b_result), .nrn_start(b_nrn_start), .nrn_in(b_nrn_in),
        .nrn_weight(b_nrn_weight), .nrn_out(b_nrn_out), .nrn_ready(b_nrn_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, expv);
    endtask

    task automatic write_pair(input logic [1:0] a, input logic [7:0] i, input logic [7:0] w);
        wr_en = 1'b1; wr_addr = a; wr_in = i; wr_weight = w;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Fills cur[] with the standard 2-cycle-per-pair stream of four pairs.
    task automatic load_table(input logic [7:0] p [8]);
        for (int k = 0; k < 11; k++) begin
            cur[k].start = (k == 0);
            cur[k].bsy   = (k <= 9);
            cur[k].dn    = (k == 9);
            cur[k].in_b  = (k < 8) ? p[(k / 2) * 2]     : 8'h00;
            cur[k].w_b   = (k < 8) ? p[(k / 2) * 2 + 1] : 8'h00;
        end
    endtask

    // Issues go at the current negedge and checks cycles 0..10 after the go edge.
    task automatic run(input string tag, input int inj);
        go = 1'b1;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            go = 1'b0; wr_en = 1'b0;
            chk($sformatf("%s c%0d nrn_start", tag, k), 32'(nrn_start), 32'(cur[k].start));
            chk($sformatf("%s c%0d busy", tag, k), 32'(busy), 32'(cur[k].bsy));
            chk($sformatf("%s c%0d done", tag, k), 32'(done), 32'(cur[k].dn));
            chk($sformatf("%s c%0d nrn_in", tag, k), 32'(nrn_in), 32'(cur[k].in_b));
            chk($sformatf("%s c%0d nrn_weight", tag, k), 32'(nrn_weight), 32'(cur[k].w_b));
            chk($sformatf("%s c%0d err", tag, k), 32'(err), 32'd0);
            if (k == 9) chk($sformatf("%s result", tag), 32'(result), 32'(exp_res));
            if (k == inj) begin
                wr_en = 1'b1; wr_addr = 2'd1; wr_in = 8'd9; wr_weight = 8'd9; go = 1'b1;
            end
        end
    endtask

    initial begin
        logic [7:0] p1 [8];
        logic [7:0] pz [8];
        logic [7:0] p5 [8];
        logic [7:0] b_in_exp [8];
        logic [7:0] b_w_exp [8];
        int done_cyc;

        p1 = '{8'd3, 8'd6, 8'd2, 8'd2, 8'd3, 8'd26, 8'd7, 8'd10};
        pz = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        p5 = '{8'd5, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        b_in_exp = '{8'd1, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        b_w_exp  = '{8'd2, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};

        rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_in = '0; wr_weight = '0; go = 1'b0;
        nrn_out = '0; nrn_ready = 1'b0;
        b_wr_en = 1'b0; b_wr_addr = '0; b_wr_in = '0; b_wr_weight = '0; b_go = 1'b0;
        b_nrn_out = '0; b_nrn_ready = 1'b0;
        #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        chk("reset result", 32'(result), 32'd0);
        chk("reset nrn_start", 32'(nrn_start), 32'd0);
        chk("reset nrn_in", 32'(nrn_in), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // 1: normal evaluation, ready already high when WAIT is entered
        write_pair(2'd0, 8'd3, 8'd6);
        write_pair(2'd1, 8'd2, 8'd2);
        write_pair(2'd2, 8'd3, 8'd26);
        write_pair(2'd3, 8'd7, 8'd10);
        nrn_ready = 1'b1; nrn_out = 18'd170; exp_res = 18'd170;
        load_table(p1);
        run("t1", -1);

        // 2: timeout, result holds its previous value
        nrn_ready = 1'b0; nrn_out = 18'd555;
        go = 1'b1;
        done_cyc = -1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            go = 1'b0;
            if (done) begin
                done_cyc = c;
                break;
            end
        end
        chk("t2 done cycle", 32'(done_cyc), 32'd72);
        chk("t2 err", 32'(err), 32'd1);
        chk("t2 result held", 32'(result), 32'd170);
        @(negedge clk);
        chk("t2 done pulse width", 32'(done), 32'd0);
        chk("t2 err sticky", 32'(err), 32'd1);
        chk("t2 idle busy", 32'(busy), 32'd0);

        // 3: write and go while busy are ignored
        nrn_ready = 1'b1; nrn_out = 18'd171; exp_res = 18'd171;
        run("t3a", 2);
        run("t3b", -1);

        // 4: reset in the middle of pair 2
        go = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            go = 1'b0;
        end
        chk("t4 pre-reset nrn_in", 32'(nrn_in), 32'd3);
        chk("t4 pre-reset nrn_weight", 32'(nrn_weight), 32'd26);
        rst = 1'b0;
        #1;
        chk("t4 rst busy", 32'(busy), 32'd0);
        chk("t4 rst nrn_start", 32'(nrn_start), 32'd0);
        chk("t4 rst nrn_in", 32'(nrn_in), 32'd0);
        chk("t4 rst nrn_weight", 32'(nrn_weight), 32'd0);
        chk("t4 rst result", 32'(result), 32'd0);
        chk("t4 rst done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        nrn_out = 18'd99; exp_res = 18'd99;
        load_table(pz);
        run("t4", -1);

        // 5: same-cycle write and go, then go in the first idle cycle after done
        wr_en = 1'b1; wr_addr = 2'd0; wr_in = 8'd5; wr_weight = 8'd4;
        load_table(p5);
        run("t5a", -1);
        run("t5b", -1);

        // 6: BEAT=1, M=2 instance with ready held off for three WAIT cycles
        b_wr_en = 1'b1; b_wr_addr = 1'b0; b_wr_in = 8'd1; b_wr_weight = 8'd2;
        @(negedge clk);
        b_wr_addr = 1'b1; b_wr_in = 8'd3; b_wr_weight = 8'd4;
        @(negedge clk);
        b_wr_en = 1'b0; b_nrn_out = 18'd111; b_nrn_ready = 1'b0;
        b_go = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            b_go = 1'b0;
            chk($sformatf("t6 c%0d nrn_start", k), 32'(b_nrn_start), 32'(k == 0));
            chk($sformatf("t6 c%0d busy", k), 32'(b_busy), 32'(k <= 6));
            chk($sformatf("t6 c%0d done", k), 32'(b_done), 32'(k == 6));
            chk($sformatf("t6 c%0d nrn_in", k), 32'(b_nrn_in), 32'(b_in_exp[k]));
            chk($sformatf("t6 c%0d nrn_weight", k), 32'(b_nrn_weight), 32'(b_w_exp[k]));
            if (k == 4) chk("t6 no early capture", 32'(b_result), 32'd0);
            if (k == 6) begin
                chk("t6 result", 32'(b_result), 32'd777);
                chk("t6 err", 32'(b_err), 32'd0);
                b_nrn_ready = 1'b0; b_nrn_out = 18'd5;
            end
            if (k == 5) begin
                b_nrn_ready = 1'b1; b_nrn_out = 18'd777;
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/neuron_feeder.md
Name: neuron_feeder

Overview:
- Drives the neuron's operand interface: holds M input/weight byte pairs written by the host and, on a go pulse, streams them to the neuron core one pair per BEAT cycles.
- Waits for the core's ready, captures its N-bit weighted sum and reports done, or err on timeout.
- Sits between the host/config logic and the neuron core; the core-side ports connect straight to the core's start, in, weight, out and ready.

Parameters:
N, 18, neuron result width
M, 4, number of input/weight pairs per evaluation
AW, 2, pair address width (2^AW >= M)
BEAT, 2, clock cycles each pair is held on nrn_in/nrn_weight (>=1)
TIMEOUT, 64, max cycles waited in WAIT for nrn_ready (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
wr_en  in  1  host write strobe
wr_addr  in  AW  pair index (>= M ignored)
wr_in  in  8  input byte to store
wr_weight  in  8  weight byte to store
go  in  1  start evaluation (sampled in IDLE only)
busy  out  1  sequence in progress
done  out  1  one-cycle completion pulse
err  out  1  timeout flag, sticky until next accepted go
result  out  N  captured neuron output
nrn_start  out  1  start to neuron core
nrn_in  out  8  input byte to core
nrn_weight  out  8  weight byte to core
nrn_out  in  N  core result
nrn_ready  in  1  core result valid

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; pair memory cleared to 0; counters 0.
- All outputs are registered.
- States: IDLE, START, FEED, WAIT, DONE.
- IDLE: busy=0.
  - wr_en with wr_addr<M writes the pair.
  - go=1 -> START; err cleared.
  - If wr_en and go occur in the same cycle, the write is applied first and its value is used (write-first).
- START, 1 cycle: nrn_start=1; pair 0 on nrn_in/nrn_weight. This cycle counts as beat 1 of pair 0.
- FEED: pair k held for BEAT cycles total, START included for k=0; then k+1. After the last beat of pair M-1 -> WAIT.
  - Total cycles for START+FEED = M*BEAT.
- WAIT: nrn_in/nrn_weight = 0; wait counter increments each cycle.
  - nrn_ready=1 sampled -> result<=nrn_out, go to DONE.
  - Counter reaching TIMEOUT without ready -> err=1, result unchanged, go to DONE.
- DONE, 1 cycle: done=1 -> IDLE.
- busy=1 in START, FEED, WAIT and DONE.
- Ignored conditions:
  - wr_en while busy: memory unchanged.
  - go while busy: no effect, no queuing.
  - nrn_ready outside WAIT.
  - wr_addr >= M.
- Latency with ready already high on entry to WAIT: go sampled at edge e0 -> done high in the cycle after edge e(M*BEAT+1). Defaults: done 9 cycles after the go edge; busy high from e0+1 through the done cycle.
- A new go is accepted in the first IDLE cycle after DONE; the memory is retained across evaluations.
- Reset mid-sequence: immediate return to the reset state; the in-flight result is discarded; nrn_start drops asynchronously.
- result is updated only on a successful capture and holds between evaluations.

Test Plan:
1. Load (3,6),(2,2),(3,26),(7,10) at addr 0..3; go; behavioural core asserts ready with out=170 on the first WAIT cycle. Expect:
   - nrn_start for exactly 1 cycle;
   - nrn_in/nrn_weight sequence 3/6,3/6,2/2,2/2,3/26,3/26,7/10,7/10, two cycles each;
   - result=170, done 9 cycles after the go edge, err=0.
2. Core never raises ready -> err=1 and done pulse after TIMEOUT WAIT cycles; result keeps its prior value (170).
3. While busy: wr_en to addr 1 with (9,9), plus an extra go. Expect the streamed data unchanged, no second sequence, and memory addr1 still (2,2) on the next run.
4. rst low during FEED pair 2 -> all outputs 0 at once. After release, a go with no writes streams 0/0 pairs (memory cleared).
5. Same-cycle wr_en (addr0, 5,4) and go in IDLE -> first pair streamed is 5/4. Then a back-to-back go in the first IDLE cycle after done is accepted.
6. BEAT=1, M=2 instance: pairs each held 1 cycle; ready delayed 3 WAIT cycles -> done at go edge + M*BEAT + 4 cycles; result captures nrn_out sampled with ready.
